csr_timer: RTL
==============

Name: csr_timer

Overview:
- Constant timer and stable-counter unit for the LoongArch CSR file.
- Owns TID, TCFG, TVAL and the TICLR clear action.
- Produces the timer-interrupt level that the CSR block merges into ESTAT.IS[11].
- Provides the 64-bit stable counter and counter ID read by RDCNTVL.W, RDCNTVH.W and RDCNTID.
- Sits directly upstream of the CSR block, which forwards decoded writes and muxes these read values.

Parameters:
TIMER_N, 32, timer width n (TCFG.InitVal = tcfg[TIMER_N-1:2]); legal range 8..32
CNT_W, 64, stable counter width; must be 64

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
tcfg_we  in  1  write strobe for TCFG
tid_we  in  1  write strobe for TID
ticlr_we  in  1  write strobe for TICLR
wdata  in  32  CSR write data
wmask  in  32  CSR write mask; new = wmask&wdata | ~wmask&old
tcfg_rdata  out  32  TCFG value, zero-extended above TIMER_N
tval_rdata  out  32  TVAL value, zero-extended above TIMER_N
tid_rdata  out  32  TID value
cnt_vl  out  32  stable counter [31:0]
cnt_vh  out  32  stable counter [63:32]
ti_int  out  1  timer interrupt pending (level)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - tcfg = 0.
  - tval = all ones (TIMER_N bits).
  - tid = 0.
  - stable counter = 0.
  - ti_int = 0.
  - state = IDLE.
- Reset asserted mid-count returns every register to its reset value on the next edge.
- All read outputs are direct register outputs with 0-cycle combinational read latency. A write becomes visible the cycle after the strobe.
- The strobes are mutually exclusive; the CSR block decodes one csr_num.
- TCFG fields: bit0 En, bit1 Periodic, [TIMER_N-1:2] InitVal. Bits above TIMER_N-1 are not stored and read 0.
- Reload value R = {InitVal, 2'b00}.
- FSM states: IDLE, COUNT, STOP.
- TCFG write, which has priority over every other timer event in the same cycle:
  - tcfg takes the masked merge.
  - If the merged En = 1: tval <= R, state <= COUNT.
  - If the merged En = 0: tval holds, state <= IDLE.
  - An expiry coinciding with a TCFG write is discarded and ti_int is not set.
- IDLE: tval holds; no interrupt generated.
- COUNT, no TCFG write:
  - If tval != 0: tval <= tval - 1.
  - If tval == 0 (expiry): set ti_int. Then, if Periodic = 1, tval <= R and stay in COUNT; otherwise tval <= all ones and go to STOP.
- STOP: tval holds all ones. No further expiry until TCFG is rewritten with En = 1.
- InitVal = 0 with Periodic = 1 is legal: tval is loaded with 0 and expires every cycle.
- Expiry period: exactly R+1 cycles from the load edge to the cycle ti_int is first seen high.
- TICLR:
  - ticlr_we with wmask[0] & wdata[0] clears ti_int next cycle. Other bits are ignored; there is no TICLR storage.
  - Set and clear in the same cycle: set wins, ti_int = 1.
- ti_int stays high until cleared by TICLR or reset. Disabling En does not clear it.
- TID: masked merge on tid_we; no other updates.
- Stable counter:
  - Increments by 1 every cycle after reset, regardless of timer state and writes.
  - Wraps from 2^64-1 to 0.
  - Not software-writable.
  - cnt_vl and cnt_vh come from the same register; readers sampling both across cycles accept tearing.

Test Plan:
- Reset then 10 idle cycles -> tval_rdata = 0xFFFFFFFF, tcfg_rdata = 0, ti_int = 0, cnt_vl = 10, cnt_vh = 0.
- TCFG write 0x0000_0011 (InitVal = 4, one-shot, En) -> tval = 0x10 next cycle, counts down to 0. ti_int rises 17 cycles after the load edge, then tval = 0xFFFFFFFF and holds; no second interrupt after 100 cycles.
- TCFG write 0x0000_000B (InitVal = 2, periodic) -> tval sequence 8,7,…,0,8,…; expiry every 9 cycles. TICLR write wdata = 1 after each expiry -> ti_int low the next cycle, high again 9 cycles later.
- TICLR write in the exact cycle tval == 0 in COUNT -> ti_int = 1 after the edge (set wins).
- TCFG rewrite while tval == 0 in COUNT -> no interrupt set; tval reloads with the new R. TCFG write with En = 0 mid-count (tval = 5) -> tval holds at 5 forever.
- Force the stable counter to 0x0000_0000_FFFF_FFFE via the bench and run 3 cycles -> cnt_vh goes from 0 to 1 as cnt_vl wraps to 0, final cnt_vl = 1. TID write wdata = 0xA5A5_0000 with wmask = 0xFFFF_0000 over 0x1234_5678 -> tid_rdata = 0xA5A5_5678.

Source files
------------

// File: rtl/csr_timer.sv
// csr_timer: LoongArch constant timer (TCFG/TVAL/TID/TICLR) and the 64-bit
// stable counter used by RDCNTVL.W / RDCNTVH.W / RDCNTID.
// Timer interrupt is a level held until software clears it through TICLR.
module csr_timer #(
  parameter int TIMER_N = 32,
  parameter int CNT_W   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  logic        tid_we,
  input  logic        ticlr_we,
  input  logic [31:0] wdata,
  input  logic [31:0] wmask,
  output logic [31:0] tcfg_rdata,
  output logic [31:0] tval_rdata,
  output logic [31:0] tid_rdata,
  output logic [31:0] cnt_vl,
  output logic [31:0] cnt_vh,
  output logic        ti_int
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t             state_r;
  logic [TIMER_N-1:0] tcfg_r;
  logic [TIMER_N-1:0] tval_r;
  logic [31:0]        tid_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ti_int_r;

  logic [TIMER_N-1:0] tcfg_merged_s;
  logic [TIMER_N-1:0] reload_s;
  logic [TIMER_N-1:0] new_reload_s;
  logic [31:0]        tid_merged_s;
  logic               expire_s;
  logic               ticlr_s;

  // Masked merges, reload values and the timer event qualifiers.
  always_comb begin
    tcfg_merged_s = (wmask[TIMER_N-1:0] & wdata[TIMER_N-1:0]) |
                    (~wmask[TIMER_N-1:0] & tcfg_r);
    reload_s      = {tcfg_r[TIMER_N-1:2], 2'b00};
    new_reload_s  = {tcfg_merged_s[TIMER_N-1:2], 2'b00};
    tid_merged_s  = (wmask & wdata) | (~wmask & tid_r);
    // A TCFG write in the same cycle swallows the expiry.
    expire_s      = (state_r == COUNT) && (tval_r == {TIMER_N{1'b0}}) && !tcfg_we;
    ticlr_s       = ticlr_we & wmask[0] & wdata[0];
  end

  // Timer FSM: TCFG write has priority, then countdown / reload / stop, plus interrupt level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      tcfg_r   <= {TIMER_N{1'b0}};
      tval_r   <= {TIMER_N{1'b1}};
      ti_int_r <= 1'b0;
    end else begin
      // Set beats clear when both land in the same cycle.
      if (expire_s) begin
        ti_int_r <= 1'b1;
      end else if (ticlr_s) begin
        ti_int_r <= 1'b0;
      end else begin
        ti_int_r <= ti_int_r;
      end

      if (tcfg_we) begin
        tcfg_r <= tcfg_merged_s;
        if (tcfg_merged_s[0]) begin
          tval_r  <= new_reload_s;
          state_r <= COUNT;
        end else begin
          state_r <= IDLE;
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          COUNT: begin
            if (tval_r != {TIMER_N{1'b0}}) begin
              tval_r <= tval_r - TIMER_N'(1);
            end else if (tcfg_r[1]) begin
              tval_r <= reload_s;
            end else begin
              tval_r  <= {TIMER_N{1'b1}};
              state_r <= STOP;
            end
          end
          STOP: begin
            tval_r <= {TIMER_N{1'b1}};
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // TID register: software-owned identifier, masked merge on write.
  always_ff @(posedge clk) begin
    if (reset) begin
      tid_r <= 32'h0000_0000;
    end else if (tid_we) begin
      tid_r <= tid_merged_s;
    end else begin
      tid_r <= tid_r;
    end
  end

  // Stable counter: free-running, wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tcfg_rdata = 32'(tcfg_r);
  assign tval_rdata = 32'(tval_r);
  assign tid_rdata  = tid_r;
  assign cnt_vl     = cnt_r[31:0];
  assign cnt_vh     = cnt_r[CNT_W-1:32];
  assign ti_int     = ti_int_r;

endmodule
